mac_dsr_frame: RTL and testbench
================================

Name: mac_dsr_frame

Overview:
- Parametrised, pipelined signed multiply-accumulate engine that computes framed dot products of programmable length.
- Operands carry an in_valid qualifier and bubbles are allowed.
- Each completed frame is presented on a registered z with a one-cycle out_valid strobe.
- Sits in the arithmetic datapath as the next-generation MAC for filter and dot-product kernels.

Parameters:
- DATA_W, 8, signed operand width of a and b
- ACC_W, 16, accumulator and result width; must be >= 2*DATA_W (elaboration-time check, fatal otherwise)
- CNT_W, 8, width of the frame-length input and the internal product counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- a  input  DATA_W  signed operand A
- b  input  DATA_W  signed operand B
- in_valid  input  1  a and b are valid this cycle
- len  input  CNT_W  products per frame; quasi-static; 0 is treated as 1
- clear  input  1  synchronous frame abort / pipeline flush
- z  output  ACC_W  signed result of the last completed frame
- out_valid  output  1  one-cycle strobe; z was updated this cycle
- busy  output  1  a frame or in-flight product is pending
- ovf  output  1  saturation flag (see Optional Feature); constant 0 when the feature is absent

Behaviour:
- Pipeline stages:
  - S1: a_reg, b_reg, v1 <= a, b, in_valid.
  - S2: prod <= a_reg*b_reg at full 2*DATA_W signed width; v2 <= v1.
  - S3: accumulate / complete the frame.
- Latency: in_valid sampled high in cycle k gives that product's effect in S3 at the edge ending cycle k+2. If it is the last product of a frame, out_valid is high during cycle k+3.
- Operand handling: prod is sign-extended to ACC_W. Arithmetic is two's complement and wraps modulo 2^ACC_W unless the Optional Feature is enabled.
- Product counter: cnt counts products accepted into S3.
- First product of a frame (v2 && cnt==0):
  - len_q <= max(len,1).
  - acc <= prod (load, not add).
  - len changes at any other time are ignored.
- Frame completion (v2 && cnt==len_q-1, including len_q==1):
  - z <= acc_next, where acc_next is acc+prod, or prod for the first product.
  - out_valid <= 1; cnt <= 0; acc <= 0.
- Other v2 cycles: acc <= acc+prod; cnt <= cnt+1.
- Bubble cycles (v2==0): acc, cnt and z are held; out_valid <= 0.
- Output hold: z holds its value between frames. out_valid is never high for two consecutive cycles unless two frames complete back-to-back (this is legal when len_q==1).
- busy = (cnt!=0) | v1 | v2, computed combinationally from registers.
- clear (has priority over data):
  - v1, v2, acc, cnt, out_valid <= 0.
  - z and len_q are unchanged.
  - Operands presented in the same cycle as clear are discarded.
- reset (has priority over clear): every register, including z, len_q, out_valid and ovf, goes to 0. busy is 0 the cycle after reset.
- Reset or clear mid-frame: the partial frame is discarded and no out_valid is produced for it.

Optional Feature:
- Macro: MAC_DSR_FRAME_SAT_EN.
- When defined:
  - Each S3 addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - ovf goes high when any addition in the current frame clipped, and updates with z at frame completion.
  - ovf holds until the next completion, clear or reset; clear and reset set it to 0.
- When undefined: arithmetic wraps and ovf is tied to 0.

Test Plan:
(DATA_W=8, ACC_W=16)
1. Reset, len=1, single input a=3 b=4 in cycle k -> out_valid only in cycle k+3 with z=12; busy drops to 0 afterwards.
2. len=4, back-to-back inputs (1,2),(-3,5),(7,-1),(-8,-8) -> exactly one out_valid pulse, 3 cycles after the last input, with z=44.
3. Same data as scenario 2 with 1-3 idle cycles between inputs -> z=44; pulse 3 cycles after the last valid input; z holds its previous value until then.
4. len=4, a=b=-128 on all four inputs -> without the macro z=0 (65536 wraps); with MAC_DSR_FRAME_SAT_EN z=32767 and ovf=1.
5. len=4, two products accepted, then clear; then len=2 with (2,3),(4,5) -> no pulse for the aborted frame, then z=26; z keeps 44 from the prior frame until the new pulse.
6. reset asserted while a frame has 2 products in S3 and 1 in flight -> next cycle z=0, out_valid=0, busy=0, ovf=0; a subsequent len=1 input (5,5) -> z=25.

Source files
------------

// File: rtl/mac_dsr_frame.sv
// Pipelined signed multiply-accumulate producing framed dot products of programmable length.
// Optional saturating accumulation with overflow flag: define MAC_DSR_FRAME_SAT_EN.
module mac_dsr_frame #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     in_valid,
    input  logic        [CNT_W-1:0]  len,
    input  logic                     clear,
    output logic signed [ACC_W-1:0]  z,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     ovf
);

    localparam int PROD_W = 2 * DATA_W;

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $fatal(1, "mac_dsr_frame: ACC_W must be >= 2*DATA_W");
        end
    endgenerate

    logic signed [DATA_W-1:0] a_q, b_q;
    logic                     v1_q, v2_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  z_q, z_d;
    logic signed [ACC_W-1:0]  prod_ext, acc_next;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [CNT_W-1:0]  len_q, len_d;
    logic        [CNT_W-1:0]  len_eff, len_cur;
    logic                     out_valid_q, out_valid_d;
    logic                     first, last;

    assign prod_ext = ACC_W'(prod_q);
    assign first    = (cnt_q == '0);
    assign len_eff  = (len == '0) ? CNT_W'(1) : len;
    // The frame length is latched only when the first product lands, so use the live input then.
    assign len_cur  = first ? len_eff : len_q;
    assign last     = (cnt_q == len_cur - CNT_W'(1));

`ifdef MAC_DSR_FRAME_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  clip;
    logic                  ovf_q, ovf_d;
    logic                  frame_clip_q, frame_clip_d;

    always_comb begin
        sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
        clip     = !first && (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
        if (first) begin
            acc_next = prod_ext;
        end else if (clip) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        acc_next = first ? prod_ext : acc_q + prod_ext;
    end
`endif

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        z_d         = z_q;
        out_valid_d = 1'b0;
`ifdef MAC_DSR_FRAME_SAT_EN
        ovf_d        = ovf_q;
        frame_clip_d = frame_clip_q;
`endif
        if (v2_q) begin
            if (first) begin
                len_d = len_eff;
            end
            if (last) begin
                z_d         = acc_next;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
`ifdef MAC_DSR_FRAME_SAT_EN
                ovf_d        = frame_clip_q | clip;
                frame_clip_d = 1'b0;
`endif
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef MAC_DSR_FRAME_SAT_EN
                frame_clip_d = frame_clip_q | clip;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            v1_q        <= 1'b0;
            prod_q      <= '0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef MAC_DSR_FRAME_SAT_EN
            ovf_q        <= 1'b0;
            frame_clip_q <= 1'b0;
`endif
        end else begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= PROD_W'(a_q) * PROD_W'(b_q);
            if (clear) begin
                // Flush: in-flight qualifiers and the partial frame vanish; z and len_q persist.
                v1_q        <= 1'b0;
                v2_q        <= 1'b0;
                acc_q       <= '0;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
`ifdef MAC_DSR_FRAME_SAT_EN
                ovf_q        <= 1'b0;
                frame_clip_q <= 1'b0;
`endif
            end else begin
                v1_q        <= in_valid;
                v2_q        <= v1_q;
                acc_q       <= acc_d;
                cnt_q       <= cnt_d;
                len_q       <= len_d;
                z_q         <= z_d;
                out_valid_q <= out_valid_d;
`ifdef MAC_DSR_FRAME_SAT_EN
                ovf_q        <= ovf_d;
                frame_clip_q <= frame_clip_d;
`endif
            end
        end
    end

    assign z         = z_q;
    assign out_valid = out_valid_q;
    assign busy      = (cnt_q != '0) | v1_q | v2_q;
`ifdef MAC_DSR_FRAME_SAT_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_dsr_frame.sv
// Self-checking bench for mac_dsr_frame: directed scenarios then random traffic against a
// queue-based model of products, frames, clear and reset. Honours MAC_DSR_FRAME_SAT_EN.
module tb_mac_dsr_frame;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [DATA_W-1:0] a, b;
    logic                     in_valid;
    logic        [CNT_W-1:0]  len;
    logic                     clear;
    logic signed [ACC_W-1:0]  z;
    logic                     out_valid;
    logic                     busy;
    logic                     ovf;

    always #5 clk = ~clk;

    mac_dsr_frame #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid), .len(len),
        .clear(clear), .z(z), .out_valid(out_valid), .busy(busy), .ovf(ovf)
    );

    int total = 0;
    int bad   = 0;

    // Model: products waiting to reach the accumulator, each with the cycle it lands.
    typedef struct { int due; longint p; } pend_t;
    pend_t  pq[$];
    int     t = 0;
    int     m_cnt = 0;
    int     m_len = 1;
    longint m_acc = 0;
    logic   m_clip = 1'b0;
    logic [ACC_W-1:0] exp_z = '0;
    logic   exp_ov = 1'b0;
    logic   exp_ovf = 1'b0;
    logic   exp_busy = 1'b0;
    int     frames = 0;

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_accept(input longint p);
        if (m_cnt == 0) begin
            m_len = (len == 0) ? 1 : int'(len);
            m_acc = p;
        end else begin
            m_acc = m_acc + p;
`ifdef MAC_DSR_FRAME_SAT_EN
            if (m_acc > 32767) begin
                m_acc = 32767; m_clip = 1'b1;
            end else if (m_acc < -32768) begin
                m_acc = -32768; m_clip = 1'b1;
            end
`endif
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_z  = m_acc[ACC_W-1:0];
            exp_ov = 1'b1;
`ifdef MAC_DSR_FRAME_SAT_EN
            exp_ovf = m_clip;
`endif
            frames++;
            $display("frame %0d: len=%0d z=%0d ovf=%0b (cycle %0d)", frames, m_len,
                     $signed(exp_z), exp_ovf, t + 1);
            m_cnt = 0; m_acc = 0; m_clip = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance model across the edge, then compare.
    task automatic tick(input logic v, input int aa, input int bb, input logic clr, input logic rst);
        longint p;
        pend_t  head;
        in_valid = v; a = DATA_W'(aa); b = DATA_W'(bb); clear = clr; reset = rst;
        @(posedge clk);
        exp_ov = 1'b0;
        if (rst || clr) begin
            pq.delete();
            m_cnt = 0; m_acc = 0; m_clip = 1'b0; exp_ovf = 1'b0;
            if (rst) exp_z = '0;
        end else begin
            if (pq.size() > 0 && pq[0].due == t) begin
                head = pq.pop_front();
                model_accept(head.p);
            end
            if (v) begin
                p = longint'(aa) * longint'(bb);
                pq.push_back('{t + 2, p});
            end
        end
        exp_busy = (pq.size() > 0) || (m_cnt != 0);
        #1;
        chk("out_valid", ACC_W'(out_valid), ACC_W'(exp_ov));
        chk("z", z, exp_z);
        chk("busy", ACC_W'(busy), ACC_W'(exp_busy));
        chk("ovf", ACC_W'(ovf), ACC_W'(exp_ovf));
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    int sa[4] = '{1, -3, 7, -8};
    int sb[4] = '{2, 5, -1, -8};

    initial begin
        in_valid = 1'b0; a = '0; b = '0; clear = 1'b0; reset = 1'b1; len = 8'd1;
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        chk("reset_z", z, '0);
        chk("reset_busy", ACC_W'(busy), '0);

        // Scenario 1: single product frame
        len = 8'd1;
        tick(1'b1, 3, 4, 1'b0, 1'b0);
        idle(1);
        chk("s1_no_early_pulse", ACC_W'(out_valid), '0);
        idle(1);
        chk("s1_pulse", ACC_W'(out_valid), 16'd1);
        chk("s1_z", z, 16'd12);
        idle(1);
        chk("s1_busy_low", ACC_W'(busy), '0);

        // Scenario 2: back-to-back frame of four
        len = 8'd4;
        for (int i = 0; i < 4; i++) tick(1'b1, sa[i], sb[i], 1'b0, 1'b0);
        idle(2);
        chk("s2_z", z, 16'd44);
        idle(2);

        // Scenario 3: same data with bubbles
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, sa[i], sb[i], 1'b0, 1'b0);
            if (i < 3) idle($urandom_range(1, 3));
        end
        idle(2);
        chk("s3_z", z, 16'd44);
        idle(2);

        // Scenario 5: abort after two products, then a len=2 frame
        len = 8'd4;
        tick(1'b1, 9, 9, 1'b0, 1'b0);
        tick(1'b1, 9, 9, 1'b0, 1'b0);
        idle(2);
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        chk("s5_hold_z", z, 16'd44);
        len = 8'd2;
        tick(1'b1, 2, 3, 1'b0, 1'b0);
        tick(1'b1, 4, 5, 1'b0, 1'b0);
        idle(2);
        chk("s5_z", z, 16'd26);
        idle(2);

        // Scenario 4: large products, wrap or saturate
        len = 8'd4;
        for (int i = 0; i < 4; i++) tick(1'b1, -128, -128, 1'b0, 1'b0);
        idle(2);
`ifdef MAC_DSR_FRAME_SAT_EN
        chk("s4_z_sat", z, 16'h7fff);
        chk("s4_ovf", ACC_W'(ovf), 16'd1);
`else
        chk("s4_z_wrap", z, 16'h0000);
        chk("s4_ovf", ACC_W'(ovf), 16'd0);
`endif
        idle(2);

        // Scenario 6: reset mid-frame with one product still in flight
        len = 8'd4;
        for (int i = 0; i < 3; i++) tick(1'b1, 10 + i, 3, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        chk("s6_z", z, '0);
        chk("s6_busy", ACC_W'(busy), '0);
        len = 8'd1;
        tick(1'b1, 5, 5, 1'b0, 1'b0);
        idle(2);
        chk("s6_z_after", z, 16'd25);

        // len=0 acts as 1; clear with operands in the pipe
        len = 8'd0;
        tick(1'b1, -7, 6, 1'b0, 1'b0);
        idle(2);
        chk("len0_z", z, 16'hffd6);
        len = 8'd3;
        tick(1'b1, 4, 4, 1'b0, 1'b0);
        tick(1'b1, 4, 4, 1'b1, 1'b0);
        idle(3);
        chk("clear_inflight_z", z, 16'hffd6);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) len = CNT_W'($urandom_range(0, 5));
            tick(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128,
                 ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128,
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 149) == 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
